// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC register, combinational instruction memory port and a
// registered fetch/decode stage. Optional misaligned-redirect fault under FETCH_MISALIGN_CHECK_EN.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic [31:0]           IMEM_DATA,
  input  logic                  READY,
  input  logic                  BRANCH_TAKEN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_TARGET,
  output logic [31:0]           INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  output logic                  INSTR_VALID,
  output logic                  MISALIGNED
);

  // Handshake toward decode: INSTR/INSTR_PC are offered while INSTR_VALID=1 and stay stable
  // until READY=1 at a rising edge (consumed); only a redirect or reset may withdraw them.
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           instr_q;
  logic [ADDR_WIDTH-1:0] instr_pc_q;
  logic                  valid_q;
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_pc = BRANCH_TARGET;

  // Sticky: once set, only reset clears it and further redirects are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_q <= 1'b0;
    end else if (BRANCH_TAKEN && !fault_q && (BRANCH_TARGET[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign redirect_pc = BRANCH_TARGET & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign fault_q     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (BRANCH_TAKEN && !fault_q) begin
      // Wrong-path instruction is flushed; INSTR/INSTR_PC keep their stale contents.
      pc_q    <= redirect_pc;
      valid_q <= 1'b0;
    end else if (fault_q) begin
      valid_q <= 1'b0;
    end else if (!valid_q || READY) begin
      instr_q    <= IMEM_DATA;
      instr_pc_q <= pc_q;
      valid_q    <= 1'b1;
      pc_q       <= pc_q + ADDR_WIDTH'(4);
    end
  end

  assign IMEM_ADDR   = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = valid_q;
  assign MISALIGNED  = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios from the test plan plus a randomized run
// checked against a stream-level model (next instruction address expected at decode).
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        br;
  logic [63:0] tgt;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  logic        rst_w;
  logic [63:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_instr;
  logic [63:0] w_instr_pc;
  logic        w_valid;
  logic        w_misaligned;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  // memory model: word at address a is a
  assign imem_data   = imem_addr[31:0];
  assign w_imem_data = w_imem_addr[31:0];

  instruction_fetch #(.ADDR_WIDTH(64), .RESET_PC(64'h0)) dut (
    .CLK(clk), .RST(rst), .IMEM_ADDR(imem_addr), .IMEM_DATA(imem_data),
    .READY(ready), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt),
    .INSTR(instr), .INSTR_PC(instr_pc), .INSTR_VALID(instr_valid), .MISALIGNED(misaligned)
  );

  instruction_fetch #(.ADDR_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) u_wrap (
    .CLK(clk), .RST(rst_w), .IMEM_ADDR(w_imem_addr), .IMEM_DATA(w_imem_data),
    .READY(1'b1), .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(64'h0),
    .INSTR(w_instr), .INSTR_PC(w_instr_pc), .INSTR_VALID(w_valid), .MISALIGNED(w_misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", instr); else n_pass++;
    n_checks++; if (instr_pc !== 64'h0) $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); else n_pass++;
    n_checks++; if (imem_addr !== 64'h0) $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); else n_pass++;
    n_checks++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned got=%b exp=0", misaligned); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [63:0] e;
    rst = 1'b0;
    exp_q = '{64'h0, 64'h4, 64'h8};
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (instr_valid !== 1'b1) $display("FAIL seq_valid got=%b exp=1", instr_valid); else n_pass++;
      n_checks++; if (instr_pc !== e) $display("FAIL seq_instr_pc got=%h exp=%h", instr_pc, e); else n_pass++;
      n_checks++; if (instr !== e[31:0]) $display("FAIL seq_instr got=%h exp=%h", instr, e[31:0]); else n_pass++;
      n_checks++; if (imem_addr !== e + 64'd4) $display("FAIL seq_imem_addr got=%h exp=%h", imem_addr, e + 64'd4); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (instr_pc !== 64'h8) $display("FAIL bp_hold_pc got=%h exp=8", instr_pc); else n_pass++;
      n_checks++; if (instr_valid !== 1'b1) $display("FAIL bp_hold_valid got=%b exp=1", instr_valid); else n_pass++;
      n_checks++; if (imem_addr !== 64'hC) $display("FAIL bp_hold_addr got=%h exp=c", imem_addr); else n_pass++;
    end
    ready = 1'b1;
    exp_q = '{64'hC, 64'h10};
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== e) $display("FAIL bp_release got=%b/%h exp=1/%h", instr_valid, instr_pc, e); else n_pass++;
    end
  endtask

  task automatic test_redirect();
    br = 1'b1; tgt = 64'h100;
    @(negedge clk);
    br = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL redir_bubble got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (imem_addr !== 64'h100) $display("FAIL redir_addr got=%h exp=100", imem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h100) $display("FAIL redir_target got=%b/%h exp=1/100", instr_valid, instr_pc); else n_pass++;
    n_checks++; if (instr !== 32'h100) $display("FAIL redir_instr got=%h exp=100", instr); else n_pass++;
    n_checks++; if (imem_addr !== 64'h104) $display("FAIL redir_next_addr got=%h exp=104", imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_stall();
    ready = 1'b0; br = 1'b1; tgt = 64'h40;
    @(negedge clk);
    ready = 1'b1; br = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL stall_redir_drop got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (imem_addr !== 64'h40) $display("FAIL stall_redir_addr got=%h exp=40", imem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h40) $display("FAIL stall_redir_target got=%b/%h exp=1/40", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_misaligned();
    br = 1'b1; tgt = 64'h102;
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    n_checks++; if (misaligned !== 1'b1) $display("FAIL mis_flag got=%b exp=1", misaligned); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL mis_valid got=%b exp=0", instr_valid); else n_pass++;
    n_checks++; if (imem_addr !== 64'h102) $display("FAIL mis_addr got=%h exp=102", imem_addr); else n_pass++;
    tgt = 64'h200;
    @(negedge clk);
    br = 1'b0;
    n_checks++; if (imem_addr !== 64'h102) $display("FAIL mis_redir_ignored got=%h exp=102", imem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (misaligned !== 1'b1 || instr_valid !== 1'b0) $display("FAIL mis_sticky got=%b/%b exp=1/0", misaligned, instr_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (misaligned !== 1'b0 || imem_addr !== 64'h0) $display("FAIL mis_reset_clear got=%b/%h exp=0/0", misaligned, imem_addr); else n_pass++;
`else
    br = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 64'h100) $display("FAIL mis_masked_addr got=%b/%h exp=0/100", instr_valid, imem_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h100) $display("FAIL mis_masked_target got=%b/%h exp=1/100", instr_valid, instr_pc); else n_pass++;
    n_checks++; if (misaligned !== 1'b0) $display("FAIL mis_tied_zero got=%b exp=0", misaligned); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    logic [63:0] e;
    rst_w = 1'b0;
    exp_q = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (w_valid !== 1'b1 || w_instr_pc !== e) $display("FAIL wrap_pc got=%b/%h exp=1/%h", w_valid, w_instr_pc, e); else n_pass++;
      n_checks++; if (w_instr !== e[31:0]) $display("FAIL wrap_instr got=%h exp=%h", w_instr, e[31:0]); else n_pass++;
    end
    n_checks++; if (w_misaligned !== 1'b0) $display("FAIL wrap_no_flag got=%b exp=0", w_misaligned); else n_pass++;
  endtask

  // Reference: m_next is the address of the next instruction decode should see.
  task automatic test_random();
    logic [63:0] m_next;
    logic        m_valid;
    rst = 1'b1; ready = 1'b1; br = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_next = 64'h0; m_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (instr_valid !== m_valid) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_checks++; if (instr_pc !== m_next || instr !== m_next[31:0]) $display("FAIL rnd_instr cyc=%0d got=%h/%h exp=%h", cyc, instr_pc, instr, m_next); else n_pass++;
        n_checks++; if (imem_addr !== m_next + 64'd4) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_next + 64'd4); else n_pass++;
      end else begin
        n_checks++; if (imem_addr !== m_next) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_next); else n_pass++;
      end
      n_checks++; if (misaligned !== 1'b0) $display("FAIL rnd_misaligned cyc=%0d got=%b exp=0", cyc, misaligned); else n_pass++;
      ready = ($urandom_range(0, 3) != 0);
      br    = ($urandom_range(0, 9) == 0);
      tgt   = {$urandom(), $urandom()};
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      if (br) begin
        m_next  = {tgt[63:2], 2'b00};
        m_valid = 1'b0;
      end else begin
        if (m_valid && ready) m_next = m_next + 64'd4;
        m_valid = 1'b1;
      end
      @(negedge clk);
    end
    br = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; br = 1'b1; tgt = 64'h300;
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0 || instr_pc !== 64'h0 || instr !== 32'h0) $display("FAIL reset_mid_out got=%b/%h/%h exp=0/0/0", instr_valid, instr_pc, instr); else n_pass++;
    n_checks++; if (imem_addr !== 64'h0) $display("FAIL reset_mid_addr got=%h exp=0", imem_addr); else n_pass++;
    rst = 1'b0; br = 1'b0; ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1; ready = 1'b1; br = 1'b0; tgt = 64'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_stall();
    test_misaligned();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
